// File: rtl/spi_reg_bridge_if.sv
// Signal bundle between an SPI host / register block pair and spi_reg_bridge.
// The slave modport is the bridge's view; the master modport drives SPI and returns read data.
interface spi_reg_bridge_if #(
   parameter int unsigned ADDR_W = 3
);
   logic              i_sclk;
   logic              i_cs_n;
   logic              i_mosi;
   logic              o_miso;
   logic              o_miso_oe;
   logic              o_wr_n;
   logic [ADDR_W-1:0] o_addr;
   logic [7:0]        o_data;
   logic [7:0]        i_rdata;
   logic              o_busy;

   modport slave (
      input  i_sclk, i_cs_n, i_mosi, i_rdata,
      output o_miso, o_miso_oe, o_wr_n, o_addr, o_data, o_busy
   );

   modport master (
      output i_sclk, i_cs_n, i_mosi, i_rdata,
      input  o_miso, o_miso_oe, o_wr_n, o_addr, o_data, o_busy
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning host frames (command byte + data bytes) into
// single-cycle register writes and auto-incrementing register reads.
module spi_reg_bridge #(
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic             i_clk,
   input logic             i_rst_n,
   spi_reg_bridge_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdData} state_e;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   logic                   r_sclk_d;
   logic                   r_armed;

   state_e                 r_state;
   state_e                 w_state_d;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic [7:0]             r_tx;
   logic                   r_load;
   logic                   r_skip;
   logic                   r_oe;
   logic                   r_wr_n;
   logic [ADDR_W-1:0]      r_addr;
   logic [7:0]             r_data;

   logic                   w_sclk_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_sync_ok;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_byte_done;
   logic [7:0]             w_rx_byte;
   logic                   w_wr_fire;
   logic                   w_addr_load;
   logic                   w_rd_advance;
   logic                   w_tx_pend;

   // CS synchroniser resets high so the bus looks deselected until real samples arrive.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_vld       <= '0;
         r_sclk_d    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
         r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_sclk_d    <= w_sclk_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sync_ok   = r_vld[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_rx_byte   = {r_shift[6:0], w_mosi_s};

   // A frame already in progress at reset release is ignored until CS is seen high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed <= 1'b0;
      end else if (w_sync_ok && w_cs_s) begin
         r_armed <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_byte_done  = 1'b0;
      w_wr_fire    = 1'b0;
      w_addr_load  = 1'b0;
      w_rd_advance = 1'b0;
      if (w_cs_s) begin
         w_state_d = StIdle;
      end else begin
         w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && (r_state != StIdle);
         case (r_state)
            StIdle: begin
               if (r_armed) begin
                  w_state_d = StCmd;
               end
            end
            StCmd: begin
               if (w_byte_done) begin
                  w_addr_load = 1'b1;
                  w_state_d   = w_rx_byte[7] ? StRdData : StWrData;
               end
            end
            StWrData: w_wr_fire    = w_byte_done;
            StRdData: w_rd_advance = w_byte_done;
            default:  w_state_d    = StIdle;
         endcase
      end
   end

   assign w_tx_pend = (w_addr_load && w_rx_byte[7]) || w_rd_advance;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
      end else if (w_cs_s || (r_state == StIdle)) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'h00;
      end else if (w_sclk_rise) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         r_shift   <= w_rx_byte;
      end
   end

   // Address advances the cycle after a write strobe, or right after a read byte completes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_n <= 1'b1;
         r_data <= 8'h00;
         r_addr <= '0;
      end else begin
         r_wr_n <= ~w_wr_fire;
         if (w_wr_fire) begin
            r_data <= w_rx_byte;
         end
         if (w_addr_load) begin
            r_addr <= w_rx_byte[ADDR_W-1:0];
         end else if (!r_wr_n || w_rd_advance) begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   // r_load delays the capture one cycle so i_rdata reflects the updated address.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx   <= 8'h00;
         r_load <= 1'b0;
         r_skip <= 1'b0;
         r_oe   <= 1'b0;
      end else begin
         r_oe <= (w_state_d == StRdData);
         if (w_cs_s) begin
            r_tx   <= 8'h00;
            r_load <= 1'b0;
            r_skip <= 1'b0;
         end else begin
            r_load <= w_tx_pend;
            if (r_load) begin
               r_tx <= bus.i_rdata;
            end else if (w_sclk_fall && !r_skip && (r_state == StRdData)) begin
               r_tx <= {r_tx[6:0], 1'b0};
            end
            if (w_byte_done) begin
               r_skip <= 1'b1;
            end else if (w_sclk_fall) begin
               r_skip <= 1'b0;
            end
         end
      end
   end

   assign bus.o_miso    = r_tx[7];
   assign bus.o_miso_oe = r_oe;
   assign bus.o_wr_n    = r_wr_n;
   assign bus.o_addr    = r_addr;
   assign bus.o_data    = r_data;
   assign bus.o_busy    = ~w_cs_s;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed-vector bench for spi_reg_bridge: SPI host model, downstream register
// file, strobe monitor and a randomised write/read frame run.
`timescale 1ns/1ps
module tb_spi_reg_bridge;
   localparam int HALF = 80;  // SCLK = clk/8

   typedef struct packed {
      logic            rd;
      logic [3:0][7:0] b;
      logic [7:0]      nbits;
      logic [1:0]      n_exp;
      logic [2:0][2:0] ea;
      logic [2:0][7:0] ed;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_mode = 1'b0;
   logic [7:0]  dn_regs [8];
   logic [7:0]  m_regs [8];
   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   int unsigned last_rise = 0;
   int          bitn = 0;
   logic        oe_all = 1'b1;
   logic        oe_seen = 1'b0;
   logic        prev_wr_n = 1'b1;
   logic [2:0]  q_addr [$];
   logic [7:0]  q_data [$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_reg_bridge_if #(.ADDR_W(3)) bus ();

   spi_reg_bridge #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   assign bus.i_rdata = rd_mode ? dn_regs[bus.o_addr] : (8'h40 | {5'd0, bus.o_addr});

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream register block and strobe monitor.
   always @(negedge clk) begin
      if (!bus.o_wr_n) begin
         q_addr.push_back(bus.o_addr);
         q_data.push_back(bus.o_data);
         dn_regs[bus.o_addr] = bus.o_data;
         chk("strobe_latency_le5", ((cyc - last_rise) <= 5) ? 1 : 0, 1);
         chk("strobe_one_cycle", int'(prev_wr_n), 1);
      end
      prev_wr_n = bus.o_wr_n;
      if (bus.o_miso_oe) oe_seen = 1'b1;
   end

   task automatic cs_low();
      bus.i_cs_n = 1'b0;
      bitn       = 0;
      oe_all     = 1'b1;
   endtask

   task automatic xfer_bit(input logic b, output logic r);
      bus.i_mosi = b;
      #HALF;
      bus.i_sclk = 1'b1;
      r = bus.o_miso;
      if (bitn % 8 == 7) last_rise = cyc;
      if (bitn >= 8 && !bus.o_miso_oe) oe_all = 1'b0;
      bitn++;
      #HALF;
      bus.i_sclk = 1'b0;
   endtask

   task automatic cs_high();
      #HALF;
      bus.i_cs_n = 1'b1;
      bus.i_mosi = 1'b0;
      #(4 * HALF);
   endtask

   task automatic frame(input logic [3:0][7:0] tx, input int nbits,
                        output logic [3:0][7:0] rx);
      logic r;
      rx = '0;
      cs_low();
      for (int i = 0; i < nbits; i++) begin
         xfer_bit(tx[i / 8][7 - (i % 8)], r);
         rx[i / 8][7 - (i % 8)] = r;
      end
      cs_high();
   endtask

   initial begin
      vec_t            vt [7];
      logic [3:0][7:0] rx;
      logic [3:0][7:0] tx;
      logic            r;

      bus.i_sclk = 1'b0;
      bus.i_cs_n = 1'b1;
      bus.i_mosi = 1'b0;
      for (int i = 0; i < 8; i++) dn_regs[i] = 8'h00;

      vt[0] = '{rd: 1'b0, b: {8'h00, 8'h00, 8'hA5, 8'h02}, nbits: 8'd16, n_exp: 2'd1,
                ea: {3'd0, 3'd0, 3'd2}, ed: {8'h00, 8'h00, 8'hA5}};
      vt[1] = '{rd: 1'b0, b: {8'h33, 8'h22, 8'h11, 8'h06}, nbits: 8'd32, n_exp: 2'd3,
                ea: {3'd0, 3'd7, 3'd6}, ed: {8'h33, 8'h22, 8'h11}};
      vt[2] = '{rd: 1'b1, b: {8'h00, 8'h00, 8'h00, 8'h83}, nbits: 8'd24, n_exp: 2'd2,
                ea: '0, ed: {8'h00, 8'h44, 8'h43}};
      vt[3] = '{rd: 1'b0, b: {8'h00, 8'h00, 8'hFF, 8'h01}, nbits: 8'd13, n_exp: 2'd0,
                ea: '0, ed: '0};
      vt[4] = '{rd: 1'b0, b: {8'h00, 8'h00, 8'h3C, 8'h01}, nbits: 8'd16, n_exp: 2'd1,
                ea: {3'd0, 3'd0, 3'd1}, ed: {8'h00, 8'h00, 8'h3C}};
      vt[5] = '{rd: 1'b1, b: {8'h00, 8'h00, 8'h00, 8'h87}, nbits: 8'd24, n_exp: 2'd2,
                ea: '0, ed: {8'h00, 8'h40, 8'h47}};
      vt[6] = '{rd: 1'b0, b: {8'h00, 8'h00, 8'h5A, 8'h7D}, nbits: 8'd16, n_exp: 2'd1,
                ea: {3'd0, 3'd0, 3'd5}, ed: {8'h00, 8'h00, 8'h5A}};

      // Reset values.
      #25;
      chk("rst_wr_n", int'(bus.o_wr_n), 1);
      chk("rst_addr", int'(bus.o_addr), 0);
      chk("rst_data", int'(bus.o_data), 0);
      chk("rst_miso", int'(bus.o_miso), 0);
      chk("rst_miso_oe", int'(bus.o_miso_oe), 0);
      chk("rst_busy", int'(bus.o_busy), 0);
      #80;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         q_addr.delete();
         q_data.delete();
         oe_seen = 1'b0;
         @(posedge clk);
         #7;
         frame(vt[i].b, int'(vt[i].nbits), rx);
         repeat (4) @(posedge clk);
         if (vt[i].rd) begin
            chk($sformatf("v%0d_rd_no_strobe", i), q_addr.size(), 0);
            chk($sformatf("v%0d_rd_oe", i), int'(oe_all), 1);
            for (int k = 0; k < int'(vt[i].n_exp); k++)
               chk($sformatf("v%0d_miso_byte%0d", i, k), int'(rx[k + 1]), int'(vt[i].ed[k]));
         end else begin
            chk($sformatf("v%0d_strobe_count", i), q_addr.size(), int'(vt[i].n_exp));
            chk($sformatf("v%0d_wr_oe_low", i), int'(oe_seen), 0);
            for (int k = 0; k < int'(vt[i].n_exp); k++) begin
               if (k < q_addr.size()) begin
                  chk($sformatf("v%0d_addr%0d", i, k), int'(q_addr[k]), int'(vt[i].ea[k]));
                  chk($sformatf("v%0d_data%0d", i, k), int'(q_data[k]), int'(vt[i].ed[k]));
               end
            end
         end
         chk($sformatf("v%0d_busy_after", i), int'(bus.o_busy), 0);
      end

      // Reset in the middle of a write data byte.
      q_addr.delete();
      q_data.delete();
      @(posedge clk);
      #7;
      tx = {8'h00, 8'h00, 8'hC3, 8'h02};
      cs_low();
      for (int i = 0; i < 12; i++) xfer_bit(tx[i / 8][7 - (i % 8)], r);
      chk("mid_busy", int'(bus.o_busy), 1);
      chk("mid_addr", int'(bus.o_addr), 2);
      rst_n = 1'b0;
      #1;
      chk("mrst_wr_n", int'(bus.o_wr_n), 1);
      chk("mrst_addr", int'(bus.o_addr), 0);
      chk("mrst_data", int'(bus.o_data), 0);
      chk("mrst_miso_oe", int'(bus.o_miso_oe), 0);
      chk("mrst_busy", int'(bus.o_busy), 0);
      #50;
      rst_n = 1'b1;
      for (int i = 12; i < 24; i++) xfer_bit(tx[i / 8][7 - (i % 8)], r);
      cs_high();
      chk("mrst_no_strobe", q_addr.size(), 0);
      @(posedge clk);
      #7;
      frame({8'h00, 8'h00, 8'h99, 8'h04}, 16, rx);
      chk("post_rst_count", q_addr.size(), 1);
      if (q_addr.size() > 0) begin
         chk("post_rst_addr", int'(q_addr[0]), 4);
         chk("post_rst_data", int'(q_data[0]), 8'h99);
      end

      // Random write/read frames against a register model.
      rd_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dn_regs[i] = 8'(i * 17);
         m_regs[i]  = 8'(i * 17);
      end
      for (int f = 0; f < 100; f++) begin
         logic       isrd;
         logic [2:0] a;
         int         nd;
         isrd = 1'($urandom_range(0, 1));
         a    = 3'($urandom_range(0, 7));
         nd   = int'($urandom_range(1, 3));
         tx   = '0;
         tx[0] = {isrd, 4'($urandom_range(0, 15)), a};
         for (int k = 1; k <= nd; k++) tx[k] = 8'($urandom_range(0, 255));
         q_addr.delete();
         q_data.delete();
         @(posedge clk);
         #($urandom_range(1, 19));
         frame(tx, 8 * (nd + 1), rx);
         if (isrd) begin
            chk($sformatf("r%0d_no_strobe", f), q_addr.size(), 0);
            for (int k = 0; k < nd; k++)
               chk($sformatf("r%0d_rd%0d", f, k), int'(rx[k + 1]), int'(m_regs[3'(a + k)]));
         end else begin
            chk($sformatf("r%0d_strobe_count", f), q_addr.size(), nd);
            for (int k = 0; k < nd; k++) begin
               m_regs[3'(a + k)] = tx[k + 1];
               if (k < q_addr.size()) begin
                  chk($sformatf("r%0d_addr%0d", f, k), int'(q_addr[k]), int'(3'(a + k)));
                  chk($sformatf("r%0d_data%0d", f, k), int'(q_data[k]), int'(tx[k + 1]));
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI mode-0 slave that converts host SPI frames into single-cycle register-bus writes and reads.
- Sits directly upstream of the LED/GPIO register blocks. It drives their active-low write strobe, 3-bit address and 8-bit data, and serialises their read data back onto MISO.
- All SPI inputs are oversampled by the system clock. SCLK must be at most i_clk/8.

Parameters:
ADDR_W, 3, width of o_addr; command address bits above ADDR_W are ignored.
SYNC_STAGES, 2, flip-flop synchroniser depth on i_sclk, i_cs_n and i_mosi (minimum 2).

Ports:
i_clk  input  1  system clock, 50 MHz.
i_rst_n  input  1  asynchronous active-low reset.
i_sclk  input  1  SPI clock (CPOL=0, CPHA=0), asynchronous to i_clk.
i_cs_n  input  1  SPI chip select, active low.
i_mosi  input  1  SPI data in, MSB first.
o_miso  output  1  SPI data out, MSB first.
o_miso_oe  output  1  MISO output enable; high only while a read frame is selected.
o_wr_n  output  1  register write strobe, active low, one i_clk cycle wide.
o_addr  output  ADDR_W  register address.
o_data  output  8  register write data.
i_rdata  input  8  register read data; combinational function of o_addr in the downstream block.
o_busy  output  1  synchronised chip select is asserted.

Behaviour:
- Reset values: o_miso=0, o_miso_oe=0, o_wr_n=1, o_addr=0, o_data=0, o_busy=0. State=IDLE, bit counter=0.
- Reset mid-frame: the frame is dropped. After reset release the block ignores the remainder of the frame until i_cs_n is seen high.
- Synchronisation and edge detection:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rising and falling SCLK edges are detected on the synchronised signal by comparison with a one-cycle delayed copy.
- Frame format:
  - Byte 0 is the command: bit7=1 means read, bit7=0 means write; bits[ADDR_W-1:0] are the start address.
  - Bytes 1..N are data bytes. Burst length is unlimited.
- MOSI is sampled on each detected SCLK rising edge into an 8-bit shift register. A 3-bit bit counter wraps 7->0 at each byte boundary.
- States:
  - IDLE: synchronised CS high. On CS falling go to CMD and clear the bit counter.
  - CMD: on the 8th rising edge latch o_addr, then go to WR_DATA or RD_DATA according to bit7.
  - WR_DATA:
    - On the 8th rising edge of each byte, o_data takes the byte and o_wr_n is driven low for exactly one cycle.
    - o_addr is held stable during the strobe cycle.
    - o_addr increments in the cycle after the strobe, modulo 2^ADDR_W.
  - RD_DATA: see the read-path rules below.
  - Any state: synchronised CS high returns to IDLE, sets o_miso_oe=0 and discards any partial byte.
- Read path:
  - On entering RD_DATA, and after each completed data byte, i_rdata is captured into the TX shift register one cycle after o_addr settles.
  - o_miso presents TX[7] immediately.
  - On each subsequent SCLK falling edge, except the falling edge directly after a byte's 8th rising edge, TX shifts left.
  - After each completed read byte, o_addr increments (wrapping) and the next byte is preloaded before the next rising edge.
  - o_miso_oe=1 throughout RD_DATA.
- Write strobe latency: o_wr_n falls no later than 5 i_clk cycles after the raw 8th SCLK rising edge. A strobe is never issued for a partial byte.
- Simultaneous events:
  - CS deassertion detected in the same cycle as the 8th rising edge: CS takes priority and the byte is discarded with no strobe.
  - Command byte: no write ever occurs for byte 0.
- o_busy equals the inverse of synchronised CS.
- Back-to-back frames with at least 2 SCLK periods of CS high between them must both complete correctly.

Test Plan:
1. Write frame 0x02,0xA5 -> exactly one o_wr_n low pulse with o_addr=2, o_data=0xA5; o_miso_oe stays 0.
2. Burst write 0x06,0x11,0x22,0x33 -> three strobes at addresses 6,7,0 with data 0x11,0x22,0x33 (wrap at 2^ADDR_W).
3. Read frame 0x83 followed by two dummy bytes, with i_rdata=0x40|o_addr -> MISO returns 0x43 then 0x44; o_miso_oe=1 during the frame; no o_wr_n pulse.
4. Write 0x01,0xFF but raise i_cs_n after 5 data bits -> no strobe. A following frame 0x01,0x3C writes 0x3C to address 1.
5. Assert i_rst_n low in the middle of a write data byte -> outputs return to reset values immediately and no strobe occurs. The next full frame succeeds.
6. Run at SCLK=i_clk/8 with random SCLK phase relative to i_clk, over 100 random write/read frames -> register model matches; strobe latency is never more than 5 cycles.
